// File: rtl/gpp_host_loader_pkg.sv
// Shared constants for the GPP port-B host loader: widths, FSM encoding, FIFO depth.
// Width defaults match SA_WIDTH / D_WIDTH of define.h.
package gpp_host_loader_pkg;

  localparam int DEF_AW = 10;
  localparam int DEF_DW = 32;

  localparam int FIFO_DEPTH = 2;
  localparam int WDOG_W     = 24;

  // state | meaning
  // IDLE  | waiting for load_start, core held in reset
  // LOAD  | accepting image words, writing SRAM from address 0
  // RUN   | core released, waiting for core_done
  // DUMP  | reading the result window out through the FIFO
  // DONE  | one-cycle completion, core reset reasserted
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd2;
  localparam logic [2:0] ST_DUMP = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

endpackage

// File: rtl/gpp_host_loader_out_fifo.sv
// Two-entry result FIFO between SRAM read data and the valid/ready result port.
module loader_out_fifo
  import gpp_host_loader_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  output logic          out_valid_o,
  output logic [DW-1:0] out_data_o,
  input  logic          out_ready_i,
  output logic [1:0]    count_o
);

  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    count_q;
  logic          pop;
  logic          push_ok;

  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = mem_q[rd_ptr_q];
  assign count_o     = count_q;
  assign pop         = out_valid_o && out_ready_i;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign push_ok     = push_i && ((count_q != 2'(FIFO_DEPTH)) || pop);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/gpp_host_loader.sv
// Host loader for GPP SRAM port B: load image, release core, wait Done, dump results.
// Define GPP_LOADER_TIMEOUT_EN to add a 24-bit RUN watchdog that aborts to DONE with err.
module gpp_host_loader
  import gpp_host_loader_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          load_start,
  input  logic [AW:0]   load_len,
  input  logic [AW-1:0] dump_base,
  input  logic [AW:0]   dump_len,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          core_rst,
  input  logic          core_done,
  output logic [AW-1:0] Addr2,
  output logic [DW-1:0] Data_I,
  output logic          en2,
  output logic          we2,
  input  logic [DW-1:0] Data2_O,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          err,
  output logic          done_pulse
);

  localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};

  logic [2:0]    state_q, state_d;
  logic [AW:0]   len_ld_q, len_ld_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW:0]   len_dp_q, len_dp_d;
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rcnt_q, rcnt_d;
  logic [AW:0]   acnt_q, acnt_d;
  logic [1:0]    run_cnt_q, run_cnt_d;
  logic          rd_q, rd_d;
  logic          cap_q, cap_d;
  logic          in_ready_q, in_ready_d;
  logic          core_rst_q, core_rst_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          en_q, en_d;
  logic          we_q, we_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic          done_q, done_d;

  logic          fifo_valid;
  logic [1:0]    fifo_count;
  logic          pop;
  logic [2:0]    occ;
  logic          bad_len;
  logic          finish;
  logic          wdog_expired;

  loader_out_fifo #(.DW(DW)) u_out_fifo (
    .Clk         (Clk),
    .Rst         (Rst),
    .push_i      (cap_q),
    .push_data_i (Data2_O),
    .out_valid_o (fifo_valid),
    .out_data_o  (out_data),
    .out_ready_i (out_ready),
    .count_o     (fifo_count)
  );

`ifdef GPP_LOADER_TIMEOUT_EN
  logic [WDOG_W-1:0] wdog_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)                     wdog_q <= '0;
    else if (state_q == ST_RUN)  wdog_q <= wdog_q + 1'b1;
    else                         wdog_q <= '0;
  end

  assign wdog_expired = (state_q == ST_RUN) && (wdog_q == '1);
`else
  assign wdog_expired = 1'b0;
`endif

  assign pop     = fifo_valid && out_ready;
  // Reads in the address/data pipeline plus words parked in the FIFO.
  assign occ     = {2'b00, rd_q} + {2'b00, cap_q} + {1'b0, fifo_count};
  assign bad_len = (load_len > MAX_LEN) || (dump_len > MAX_LEN);

  always_comb begin
    state_d    = state_q;
    len_ld_d   = len_ld_q;
    base_d     = base_q;
    len_dp_d   = len_dp_q;
    wptr_d     = wptr_q;
    rcnt_d     = rcnt_q;
    acnt_d     = acnt_q;
    run_cnt_d  = run_cnt_q;
    in_ready_d = in_ready_q;
    core_rst_d = core_rst_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    en_d       = 1'b0;
    we_d       = 1'b0;
    rd_d       = 1'b0;
    done_d     = 1'b0;
    cap_d      = rd_q;
    finish     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          len_ld_d = load_len;
          base_d   = dump_base;
          len_dp_d = dump_len;
          err_d    = bad_len;
          wptr_d   = '0;
          rcnt_d   = '0;
          acnt_d   = '0;
          if (!bad_len) begin
            if (load_len == '0) begin
              state_d   = ST_RUN;
              run_cnt_d = 2'd0;
            end else begin
              state_d    = ST_LOAD;
              in_ready_d = 1'b1;
            end
          end
        end
      end
      ST_LOAD: begin
        if (in_valid && in_ready_q) begin
          en_d    = 1'b1;
          we_d    = 1'b1;
          addr_d  = wptr_q[AW-1:0];
          wdata_d = in_data;
          wptr_d  = wptr_q + 1'b1;
          if (wptr_q + 1'b1 == len_ld_q) begin
            in_ready_d = 1'b0;
            state_d    = ST_RUN;
            run_cnt_d  = 2'd0;
          end
        end
      end
      ST_RUN: begin
        // First RUN cycle lets the last write land; the cycle after release masks core_done.
        case (run_cnt_q)
          2'd0: begin
            core_rst_d = 1'b0;
            run_cnt_d  = 2'd1;
          end
          2'd1:    run_cnt_d = 2'd2;
          default: if (core_done) state_d = ST_DUMP;
        endcase
        if (wdog_expired && !(run_cnt_q == 2'd2 && core_done)) begin
          err_d  = 1'b1;
          finish = 1'b1;
        end
      end
      ST_DUMP: begin
        if (len_dp_q == '0) begin
          finish = 1'b1;
        end else begin
          if ((rcnt_q < len_dp_q) && ((occ < 3'd2) || (pop && occ == 3'd2))) begin
            en_d   = 1'b1;
            addr_d = base_q + rcnt_q[AW-1:0];
            rd_d   = 1'b1;
            rcnt_d = rcnt_q + 1'b1;
          end
          if (pop) begin
            acnt_d = acnt_q + 1'b1;
            if (acnt_q + 1'b1 == len_dp_q) finish = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (finish) begin
      state_d    = ST_DONE;
      done_d     = 1'b1;
      core_rst_d = 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= ST_IDLE;
      len_ld_q   <= '0;
      base_q     <= '0;
      len_dp_q   <= '0;
      wptr_q     <= '0;
      rcnt_q     <= '0;
      acnt_q     <= '0;
      run_cnt_q  <= 2'd0;
      rd_q       <= 1'b0;
      cap_q      <= 1'b0;
      in_ready_q <= 1'b0;
      core_rst_q <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      en_q       <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_ld_q   <= len_ld_d;
      base_q     <= base_d;
      len_dp_q   <= len_dp_d;
      wptr_q     <= wptr_d;
      rcnt_q     <= rcnt_d;
      acnt_q     <= acnt_d;
      run_cnt_q  <= run_cnt_d;
      rd_q       <= rd_d;
      cap_q      <= cap_d;
      in_ready_q <= in_ready_d;
      core_rst_q <= core_rst_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      en_q       <= en_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign core_rst   = core_rst_q;
  assign Addr2      = addr_q;
  assign Data_I     = wdata_q;
  assign en2        = en_q;
  assign we2        = we_q;
  assign out_valid  = fifo_valid;
  assign busy       = busy_q;
  assign err        = err_q;
  assign done_pulse = done_q;

endmodule
